// File: rtl/rotozoom_pkg.sv
// rotozoom_pkg
//   Shared widths, default constants and state encodings for the rotozoomer
//   per-frame parameter generator and its iterative multiplier.
package rotozoom_pkg;

    localparam int TEX_W  = 17;   // texture coordinate / stride width
    localparam int TRIG_W = 16;   // sine, cosine and scale table width
    localparam int PROD_W = 32;   // full signed product width

    localparam int DEF_SHIFT         = 21;   // 16 bits of scale plus 5 of texture enlarge
    localparam int DEF_CENTRE_X      = 320;
    localparam int DEF_CENTRE_Y      = 240;
    localparam int DEF_TABLE_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        MUL,
        COMMIT
    } state_t;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_FIN
    } mul_phase_t;

endpackage

// File: rtl/seq_mul_s16.sv
// seq_mul_s16
//   Signed 16x16 multiplier built from one adder. A start pulse accepted while
//   idle returns the exact 32-bit product with a one-cycle done pulse exactly
//   17 cycles later (16 shift-add iterations on the magnitudes, 1 sign fixup).
// Ports:
//   clk, reset        clock, asynchronous active-high reset (control only)
//   start             begin a product; ignored while a product is in flight
//   a, b              signed operands, sampled on the start cycle
//   done              one-cycle pulse, product valid from this cycle on
//   product           registered signed product, held until the next finish
module seq_mul_s16
    import rotozoom_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [TRIG_W-1:0] a,
    input  logic signed [TRIG_W-1:0] b,
    output logic                     done,
    output logic signed [PROD_W-1:0] product
);

    // 17 bits so that -32768 becomes a plain unsigned 32768.
    function automatic logic [TRIG_W:0] magnitude(input logic signed [TRIG_W-1:0] x);
        logic [TRIG_W:0] xe;
        xe = {x[TRIG_W-1], x};
        return x[TRIG_W-1] ? (~xe + 17'd1) : xe;
    endfunction

    mul_phase_t       phase;
    logic [3:0]       cnt;
    logic [TRIG_W:0]  mag_a;
    logic [TRIG_W:0]  mag_b;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand_sh;
    logic [TRIG_W:0]  mplier_sh;
    logic             neg;

    assign mag_a = magnitude(a);
    assign mag_b = magnitude(b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= MUL_IDLE;
            cnt   <= 4'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                MUL_IDLE: begin
                    if (start) begin
                        phase <= MUL_RUN;
                        cnt   <= 4'd1;
                    end
                end
                MUL_RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) phase <= MUL_FIN;
                end
                MUL_FIN: begin
                    phase <= MUL_IDLE;
                    done  <= 1'b1;
                end
                default: phase <= MUL_IDLE;
            endcase
        end
    end

    // Bit 0 of the multiplier is folded into the load cycle, so the load plus
    // 15 run cycles cover all 16 multiplier bits.
    always_ff @(posedge clk) begin
        if (phase == MUL_IDLE && start) begin
            acc       <= mag_b[0] ? {15'd0, mag_a} : '0;
            mcand_sh  <= {14'd0, mag_a, 1'b0};
            mplier_sh <= mag_b >> 1;
            neg       <= a[TRIG_W-1] ^ b[TRIG_W-1];
        end else if (phase == MUL_RUN) begin
            acc       <= acc + (mplier_sh[0] ? mcand_sh : '0);
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
        end else if (phase == MUL_FIN) begin
            product   <= neg ? (~acc + 32'd1) : acc;
        end
    end

endmodule

// File: rtl/rotozoom_frame_setup.sv
// rotozoom_frame_setup
//   Per-frame parameter generator for the rotozoomer raster loop. Owns the
//   9-bit animation angle, drives the table indices, and once per frame forms
//   the u/v strides and line-0 origin through one shared iterative multiplier.
//   The four results are presented together with a one-cycle params_valid.
// Ports:
//   clk, reset                 pixel clock, asynchronous active-high reset
//   frame_start                one-cycle pulse on the vsync falling edge
//   angle_idx, scale_idx       angle[7:0] and angle[8:1] to the tables
//   sin_val, cos_val, scale_val signed table data
//   u_stride, v_stride         per-pixel u/v steps
//   u_start0, v_start0         u/v origin of line 0
//   params_valid               high in the single cycle the new set appears
//   busy                       high whenever a frame setup is in progress
module rotozoom_frame_setup
    import rotozoom_pkg::*;
#(
    parameter int ROTATE_CENTRE_X = DEF_CENTRE_X,
    parameter int ROTATE_CENTRE_Y = DEF_CENTRE_Y,
    parameter int SHIFT           = DEF_SHIFT,
    parameter int TABLE_LATENCY   = DEF_TABLE_LATENCY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    output logic [7:0]               angle_idx,
    output logic [7:0]               scale_idx,
    input  logic signed [TRIG_W-1:0] sin_val,
    input  logic signed [TRIG_W-1:0] cos_val,
    input  logic signed [TRIG_W-1:0] scale_val,
    output logic signed [TEX_W-1:0]  u_stride,
    output logic signed [TEX_W-1:0]  v_stride,
    output logic signed [TEX_W-1:0]  u_start0,
    output logic signed [TEX_W-1:0]  v_start0,
    output logic                     params_valid,
    output logic                     busy
);

    localparam logic signed [TRIG_W-1:0] CENTRE_X = TRIG_W'(ROTATE_CENTRE_X);
    localparam logic signed [TRIG_W-1:0] CENTRE_Y = TRIG_W'(ROTATE_CENTRE_Y);

    // Arithmetic shift floors toward minus infinity; the truncation keeps the
    // texture-coordinate bits.
    function automatic logic signed [TEX_W-1:0] scale_down(input logic signed [PROD_W-1:0] p);
        return TEX_W'(p >>> SHIFT);
    endfunction

    function automatic logic signed [TEX_W-1:0] negate_tex(input logic signed [TEX_W-1:0] x);
        return -x;
    endfunction

    state_t                    state;
    state_t                    state_nxt;
    logic [8:0]                angle;
    logic [7:0]                fetch_cnt;
    logic                      fetch_last;
    logic [1:0]                prod_idx;
    logic [1:0]                sel_idx;
    logic                      start_pending;
    logic                      mul_start;
    logic                      mul_done;
    logic signed [TRIG_W-1:0]  mul_a;
    logic signed [TRIG_W-1:0]  mul_b;
    logic signed [PROD_W-1:0]  mul_product;
    logic signed [TEX_W-1:0]   result;
    logic signed [TRIG_W-1:0]  op_sin;
    logic signed [TRIG_W-1:0]  op_cos;
    logic signed [TRIG_W-1:0]  op_scale;
    logic signed [TEX_W-1:0]   shadow_r0;
    logic signed [TEX_W-1:0]   shadow_r1;
    logic signed [TEX_W-1:0]   shadow_r2;

    assign angle_idx    = angle[7:0];
    assign scale_idx    = angle[8:1];
    assign busy         = (state != IDLE);
    assign params_valid = (state == COMMIT);
    assign fetch_last   = (state == FETCH) && (fetch_cnt == 8'(TABLE_LATENCY - 1));
    assign result       = scale_down(mul_product);

    seq_mul_s16 u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Products run back to back: each done immediately launches the next, so
    // the MUL state spans one launch cycle plus four 17-cycle products.
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        sel_idx   = prod_idx + 2'd1;
        case (state)
            IDLE:   if (frame_start) state_nxt = FETCH;
            FETCH:  if (fetch_last) state_nxt = MUL;
            MUL: begin
                if (start_pending) begin
                    mul_start = 1'b1;
                    sel_idx   = 2'd0;
                end else if (mul_done) begin
                    if (prod_idx == 2'd3) state_nxt = COMMIT;
                    else                  mul_start = 1'b1;
                end
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_a = op_scale;
        mul_b = op_cos;
        case (sel_idx)
            2'd0: begin mul_a = op_scale; mul_b = op_cos; end
            2'd1: begin mul_a = op_scale; mul_b = op_sin; end
            2'd2: begin mul_a = CENTRE_X; mul_b = op_cos; end
            2'd3: begin mul_a = CENTRE_Y; mul_b = op_sin; end
            default: ;
        endcase
    end

    // The last product bypasses its shadow so all four outputs load on the
    // edge into COMMIT; params_valid is high for exactly that new set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            angle         <= 9'd0;
            fetch_cnt     <= 8'd0;
            prod_idx      <= 2'd0;
            start_pending <= 1'b0;
            u_stride      <= '0;
            v_stride      <= '0;
            u_start0      <= '0;
            v_start0      <= '0;
        end else begin
            state         <= state_nxt;
            start_pending <= fetch_last;
            fetch_cnt     <= (state == FETCH) ? fetch_cnt + 8'd1 : 8'd0;
            if (state == FETCH)
                prod_idx <= 2'd0;
            else if (state == MUL && mul_done)
                prod_idx <= prod_idx + 2'd1;
            if (state == MUL && mul_done && prod_idx == 2'd3) begin
                u_stride <= shadow_r0;
                v_stride <= shadow_r1;
                u_start0 <= negate_tex(shadow_r2);
                v_start0 <= result;
            end
            if (state == COMMIT) angle <= angle + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fetch_last) begin
            op_sin   <= sin_val;
            op_cos   <= cos_val;
            op_scale <= scale_val;
        end
        if (state == MUL && mul_done) begin
            case (prod_idx)
                2'd0: shadow_r0 <= result;
                2'd1: shadow_r1 <= result;
                2'd2: shadow_r2 <= result;
                default: ;
            endcase
        end
    end

endmodule
